lsu_mem_stage: RTL and testbench



---
 rtl/lsu_mem_stage.sv | 137 +++++++++++++
 tb/tb_lsu_mem_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Load/store unit: turns byte/half/word datapath accesses into word-aligned,
// byte-enabled handshaked bus cycles, stalls the core while one is in flight.
module lsu_mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [31:0] rd_q;
    logic [1:0]  sz_q;
    logic        sext_q;
    logic [1:0]  lo_q;

    logic        access;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane;
    logic [31:0] ld_data;

    assign access   = memread | memwrite;
    assign misalign = access & ((size == 2'b01 & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));

    // Gated by rst so the core is never frozen while the unit is held in reset.
    assign stall    = rst & (((state == IDLE) & access & ~misalign) | (state == REQ));
    assign readdata = misalign ? 32'h0 : rd_q;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = writedata;
        unique case (size)
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{writedata[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{writedata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = writedata;
            end
        endcase
    end

    // Extraction uses the registered size/offset, not the live datapath inputs.
    always_comb begin
        lane    = mem_rdata >> {lo_q, 3'b000};
        ld_data = mem_rdata;
        unique case (sz_q)
            2'b00:   ld_data = {{24{sext_q & lane[7]}}, lane[7:0]};
            2'b01:   ld_data = {{16{sext_q & lane[15]}}, lane[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 16'h0;
            rd_q      <= 32'h0;
            sz_q      <= 2'b00;
            sext_q    <= 1'b0;
            lo_q      <= 2'b00;
            bus_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (access && !misalign) begin
                        state     <= REQ;
                        cnt       <= 16'h0;
                        mem_req   <= 1'b1;
                        mem_we    <= memwrite;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_be    <= be_next;
                        mem_wdata <= memwrite ? wdata_next : 32'h0;
                        sz_q      <= size;
                        sext_q    <= sign_ext;
                        lo_q      <= addr[1:0];
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we) rd_q <= ld_data;
                    end else if (cnt == TO_LAST) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        rd_q    <= 32'h0;
                        bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= 16'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: stimulus queues expected bus cycles and
// load results, a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_mem_stage;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          len;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stall_cycles;
    } resp_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    lsu_mem_stage #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .memread   (memread),
        .memwrite  (memwrite),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: bus cycles are matched on mem_req rising, results on stall falling.
    initial begin
        bus_exp_t  cur;
        resp_exp_t r;
        logic      have_cur = 1'b0;
        logic      prev_req = 1'b0;
        logic      prev_stall = 1'b0;
        int        req_len = 0;
        int        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                have_cur   = 1'b0;
                prev_req   = 1'b0;
                prev_stall = 1'b0;
                req_len    = 0;
                stall_cnt  = 0;
            end else begin
                if (mem_req && !prev_req) begin
                    req_len = 0;
                    if (bus_q.size() == 0) begin
                        check("unexpected_bus_req", 32'(mem_req), 32'h0);
                    end else begin
                        cur      = bus_q.pop_front();
                        have_cur = 1'b1;
                        check("mem_addr",  mem_addr,       cur.addr);
                        check("mem_be",    32'(mem_be),    32'(cur.be));
                        check("mem_we",    32'(mem_we),    32'(cur.we));
                        check("mem_wdata", mem_wdata,      cur.wdata);
                    end
                end else if (mem_req && have_cur) begin
                    check("mem_addr_hold", mem_addr,    cur.addr);
                    check("mem_be_hold",   32'(mem_be), 32'(cur.be));
                end
                if (mem_req) req_len++;
                if (!mem_req && prev_req && have_cur) begin
                    check("req_cycles", 32'(req_len), 32'(cur.len));
                    have_cur = 1'b0;
                end

                if (stall) begin
                    stall_cnt++;
                end else begin
                    if (prev_stall) begin
                        if (resp_q.size() == 0) begin
                            check("unexpected_completion", 32'(prev_stall), 32'h0);
                        end else begin
                            r = resp_q.pop_front();
                            check("readdata",     readdata,        r.rdata);
                            check("bus_err",      32'(bus_err),    32'(r.err));
                            check("stall_cycles", 32'(stall_cnt),  32'(r.stall_cycles));
                        end
                    end
                    stall_cnt = 0;
                end
                prev_req   = mem_req;
                prev_stall = stall;
            end
        end
    end

    // One complete access; ack_at is the REQ cycle carrying mem_ack (0 = never).
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sx, input logic [31:0] a, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rdat,
                             input bus_exp_t bx, input resp_exp_t rx);
        bus_q.push_back(bx);
        resp_q.push_back(rx);
        memread   = rd;
        memwrite  = wr;
        size      = sz;
        sign_ext  = sx;
        addr      = a;
        writedata = wd;
        @(posedge clk); #1;
        addr      = ~a;
        writedata = ~wd;
        size      = ~sz;
        sign_ext  = ~sx;
        for (int k = 1; k <= 20; k++) begin
            if (k == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdat;
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            if (!stall) break;
            if (k == 20) check("access_completes", 32'(stall), 32'h0);
        end
        addr      = a;
        writedata = wd;
        size      = sz;
        sign_ext  = sx;
        @(posedge clk); #1;
        memread  = 1'b0;
        memwrite = 1'b0;
        check("bus_err_one_cycle", 32'(bus_err), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a pending load that must not stall.
        memread = 1'b1;
        size    = 2'b10;
        addr    = 32'h40;
        #12;
        check("rst_stall",     32'(stall),    32'h0);
        check("rst_mem_req",   32'(mem_req),  32'h0);
        check("rst_mem_addr",  mem_addr,      32'h0);
        check("rst_mem_be",    32'(mem_be),   32'h0);
        check("rst_mem_wdata", mem_wdata,     32'h0);
        check("rst_readdata",  readdata,      32'h0);
        check("rst_bus_err",   32'(bus_err),  32'h0);
        memread = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;

        // Misaligned word load, half store and reserved-size load: no bus cycle.
        memread = 1'b1; size = 2'b10; addr = 32'h102;
        #1;
        check("mis_word_flag",  32'(misalign), 32'h1);
        check("mis_word_stall", 32'(stall),    32'h0);
        @(posedge clk); #1;
        check("mis_word_req",   32'(mem_req),  32'h0);
        memread = 1'b0; memwrite = 1'b1; size = 2'b01; addr = 32'h1; writedata = 32'h1234;
        #1;
        check("mis_half_flag",  32'(misalign), 32'h1);
        check("mis_half_stall", 32'(stall),    32'h0);
        @(posedge clk); #1;
        check("mis_half_req",   32'(mem_req),  32'h0);
        memwrite = 1'b0; memread = 1'b1; size = 2'b11; addr = 32'h101;
        #1;
        check("mis_rsvd_flag",  32'(misalign), 32'h1);
        size = 2'b01; addr = 32'h102;
        #1;
        check("aligned_half_flag", 32'(misalign), 32'h0);
        memread = 1'b0;
        @(posedge clk); #1;
        check("mis_no_req", 32'(mem_req), 32'h0);

        // Word store, ack in third REQ cycle.
        do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 3, 32'h0,
                  '{32'h100, 4'b1111, 1'b1, 32'hDEADBEEF, 3}, '{32'h0, 1'b0, 4});
        // Byte store to lane 3, immediate ack.
        do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 1, 32'h0,
                  '{32'h100, 4'b1000, 1'b1, 32'hA5A5A5A5, 1}, '{32'h0, 1'b0, 2});
        // Signed then unsigned byte load from lane 2.
        do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 2, 32'h11802233,
                  '{32'h100, 4'b0100, 1'b0, 32'h0, 2}, '{32'hFFFFFF80, 1'b0, 3});
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1, 32'h11802233,
                  '{32'h100, 4'b0100, 1'b0, 32'h0, 1}, '{32'h00000080, 1'b0, 2});
        // Zero-extended byte from lane 1, zero-extended low half.
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1, 32'h0000FF00,
                  '{32'h100, 4'b0010, 1'b0, 32'h0, 1}, '{32'h000000FF, 1'b0, 2});
        do_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 1, 32'hFFFF8001,
                  '{32'h200, 4'b0011, 1'b0, 32'h0, 1}, '{32'h00008001, 1'b0, 2});
        // Signed upper half load.
        do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h206, 32'h0, 1, 32'h9ABC0000,
                  '{32'h204, 4'b1100, 1'b0, 32'h0, 1}, '{32'hFFFF9ABC, 1'b0, 2});
        // Upper half store leaves the previous load result in place.
        do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 1, 32'h0,
                  '{32'h200, 4'b1100, 1'b1, 32'hABCDABCD, 1}, '{32'hFFFF9ABC, 1'b0, 2});
        // Word load acked on the last cycle before timeout.
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 4, 32'hCAFEF00D,
                  '{32'h300, 4'b1111, 1'b0, 32'h0, 4}, '{32'hCAFEF00D, 1'b0, 5});
        // memread and memwrite together: store wins.
        do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h400, 32'h55AA55AA, 2, 32'h0,
                  '{32'h400, 4'b1111, 1'b1, 32'h55AA55AA, 2}, '{32'hCAFEF00D, 1'b0, 3});

        // Ack while idle is ignored.
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("idle_ack_readdata", readdata,      32'hCAFEF00D);
        check("idle_ack_req",      32'(mem_req),  32'h0);

        // Timeout: four REQ cycles, bus_err pulse, readdata cleared.
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 0, 32'h0,
                  '{32'h500, 4'b1111, 1'b0, 32'h0, 4}, '{32'h0, 1'b1, 5});

        // Reset mid-REQ, then a late ack.
        bus_q.push_back('{32'h600, 4'b1111, 1'b0, 32'h0, 0});
        memread = 1'b1; size = 2'b10; addr = 32'h600;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("pre_rst_req", 32'(mem_req), 32'h1);
        rst = 1'b0;
        #1;
        check("async_rst_req",   32'(mem_req), 32'h0);
        check("async_rst_stall", 32'(stall),   32'h0);
        memread = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("late_ack_req",      32'(mem_req), 32'h0);
        check("late_ack_stall",    32'(stall),   32'h0);
        check("late_ack_readdata", readdata,     32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("bus_q_empty",  32'(bus_q.size()),  32'h0);
        check("resp_q_empty", 32'(resp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
